// File: rtl/cmp128_minmax_tracker_pkg.sv
// Shared constants, state encoding and word type for the min/max tracker.
package cmp128_minmax_tracker_pkg;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned ST_W  = 3;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [ST_W-1:0]  state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_WAIT   = 3'd1;
  localparam state_t S_CMPMIN = 3'd2;
  localparam state_t S_CMPMAX = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic ORD_SIGNED   = 1'b1;
  localparam logic ORD_UNSIGNED = 1'b0;

endpackage

// File: rtl/cmp128_minmax_tracker_if.sv
// Input stream and result port of the min/max tracker.
interface cmp128_minmax_tracker_if #(
  parameter int unsigned CNT_W = 16
);
  import cmp128_minmax_tracker_pkg::*;

  logic             signed_mode;
  logic             in_valid;
  logic             in_ready;
  word_t            in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  word_t            out_min;
  word_t            out_max;
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_all_eq;
  logic             out_ovf;

  modport master (
    output signed_mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
           out_count, out_all_eq, out_ovf
  );

  modport slave (
    input  signed_mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx,
           out_count, out_all_eq, out_ovf
  );

endinterface

// File: rtl/cmp128_minmax_tracker_cmptree.sv
// 128-bit comparator: byte-wise compares merged MSB-first into EQ, unsigned LT and signed LT.
module comparatortree128
  import cmp128_minmax_tracker_pkg::*;
(
  input  word_t op1,
  input  word_t op2,
  output logic  EQ,
  output logic  LT,
  output logic  LTu
);

  localparam int unsigned CHUNK_W = 8;
  localparam int unsigned N_CHUNK = WIDTH / CHUNK_W;

  logic [N_CHUNK-1:0] chunk_eq;
  logic [N_CHUNK-1:0] chunk_lt;
  logic               eq_acc;
  logic               ltu_acc;

  // Leaf level: independent per-byte equality and less-than.
  for (genvar g = 0; g < N_CHUNK; g++) begin : g_leaf
    assign chunk_eq[g] = (op1[g*CHUNK_W +: CHUNK_W] == op2[g*CHUNK_W +: CHUNK_W]);
    assign chunk_lt[g] = (op1[g*CHUNK_W +: CHUNK_W] <  op2[g*CHUNK_W +: CHUNK_W]);
  end

  // Root: the most significant differing byte decides the unsigned order.
  always_comb begin
    eq_acc  = 1'b1;
    ltu_acc = 1'b0;
    for (int i = N_CHUNK - 1; i >= 0; i--) begin
      if (eq_acc) begin
        ltu_acc = chunk_lt[i];
        eq_acc  = chunk_eq[i];
      end
    end
  end

  assign EQ  = eq_acc;
  assign LTu = ltu_acc;
  // Differing sign bits: the negative operand is smaller; otherwise unsigned order holds.
  assign LT  = (op1[WIDTH-1] != op2[WIDTH-1]) ? op1[WIDTH-1] : ltu_acc;

endmodule

// File: rtl/cmp128_minmax_tracker.sv
// Streaming min/max/index/count tracker sharing one comparator between min and max compares.
module cmp128_minmax_tracker
  import cmp128_minmax_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  cmp128_minmax_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q,   state_d;
  word_t            min_q,     min_d;
  word_t            max_q,     max_d;
  word_t            data_q,    data_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] cur_idx_q, cur_idx_d;
  logic             all_eq_q,  all_eq_d;
  logic             ovf_q,     ovf_d;
  logic             mode_q,    mode_d;
  logic             last_q,    last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  word_t            cmp_op1;
  word_t            cmp_op2;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_ltu;
  logic             lt_sel;
  logic             accept;

  // Operand mux keyed on state only, so both comparator inputs come straight from registers.
  assign cmp_op1 = (state_q == S_CMPMAX) ? max_q  : data_q;
  assign cmp_op2 = (state_q == S_CMPMAX) ? data_q : min_q;

  comparatortree128 u_cmp (
    .op1 (cmp_op1),
    .op2 (cmp_op2),
    .EQ  (cmp_eq),
    .LT  (cmp_lt),
    .LTu (cmp_ltu)
  );

  assign lt_sel = (mode_q == ORD_SIGNED) ? cmp_lt : cmp_ltu;
  assign accept = bus.in_valid & in_ready_q;

  // Next-state and datapath update; strict less-than keeps the first occurrence on ties.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    data_d    = data_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    cur_idx_d = cur_idx_q;
    all_eq_d  = all_eq_q;
    ovf_d     = ovf_q;
    mode_d    = mode_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          min_d     = bus.in_data;
          max_d     = bus.in_data;
          min_idx_d = '0;
          max_idx_d = '0;
          count_d   = CNT_W'(1);
          all_eq_d  = 1'b1;
          ovf_d     = 1'b0;
          mode_d    = bus.signed_mode ? ORD_SIGNED : ORD_UNSIGNED;
          state_d   = bus.in_last ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (accept) begin
          data_d    = bus.in_data;
          last_d    = bus.in_last;
          cur_idx_d = count_q;
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          state_d = S_CMPMIN;
        end
      end
      S_CMPMIN: begin
        if (lt_sel) begin
          min_d     = data_q;
          min_idx_d = cur_idx_q;
        end
        if (!cmp_eq) begin
          all_eq_d = 1'b0;
        end
        state_d = S_CMPMAX;
      end
      S_CMPMAX: begin
        if (lt_sel) begin
          max_d     = data_q;
          max_idx_d = cur_idx_q;
        end
        state_d = last_q ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_WAIT);
    out_valid_d = (state_d == S_DONE);
  end

  // State, datapath and handshake registers; reset discards any partial run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      min_q       <= '0;
      max_q       <= '0;
      data_q      <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      count_q     <= '0;
      cur_idx_q   <= '0;
      all_eq_q    <= 1'b0;
      ovf_q       <= 1'b0;
      mode_q      <= ORD_UNSIGNED;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      data_q      <= data_d;
      min_idx_q   <= min_idx_d;
      max_idx_q   <= max_idx_d;
      count_q     <= count_d;
      cur_idx_q   <= cur_idx_d;
      all_eq_q    <= all_eq_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_min     = min_q;
  assign bus.out_max     = max_q;
  assign bus.out_min_idx = min_idx_q;
  assign bus.out_max_idx = max_idx_q;
  assign bus.out_count   = count_q;
  assign bus.out_all_eq  = all_eq_q;
  assign bus.out_ovf     = ovf_q;

endmodule

// File: tb/tb_cmp128_minmax_tracker.sv
// Directed-vector bench for cmp128_minmax_tracker (16-bit and 2-bit counter instances).
module tb_cmp128_minmax_tracker;
  import cmp128_minmax_tracker_pkg::*;

  typedef struct {
    word_t w [8];
    int    n;
    bit    sgn;
    int    stall;
    word_t mn;
    word_t mx;
    int    mn_i;
    int    mx_i;
    bit    eq;
  } vec_t;

  localparam word_t MAXP = {1'b0, {127{1'b1}}};
  localparam word_t MINN = {1'b1, 127'd0};
  localparam word_t ONES = '1;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cmp128_minmax_tracker_if #(.CNT_W(16)) b16 ();
  cmp128_minmax_tracker_if #(.CNT_W(2))  b2 ();

  cmp128_minmax_tracker #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(b16));
  cmp128_minmax_tracker #(.CNT_W(2))  u_dut2  (.clk(clk), .reset(reset), .bus(b2));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input bit sgn, input int stall,
                              input word_t a, input word_t b, input word_t c,
                              input word_t d, input word_t e,
                              input word_t mn, input word_t mx,
                              input int mn_i, input int mx_i, input bit eq);
    vec_t v;
    for (int i = 0; i < 8; i++) v.w[i] = '0;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    v.n = n; v.sgn = sgn; v.stall = stall;
    v.mn = mn; v.mx = mx; v.mn_i = mn_i; v.mx_i = mx_i; v.eq = eq;
    return v;
  endfunction

  function automatic bit less(input word_t a, input word_t b, input bit sgn);
    return sgn ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

  // Reference result for a run: first occurrence of smallest/largest word.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.mn = v.w[0]; r.mx = v.w[0]; r.mn_i = 0; r.mx_i = 0; r.eq = 1'b1;
    for (int i = 1; i < v.n; i++) begin
      if (less(v.w[i], r.mn, v.sgn)) begin r.mn = v.w[i]; r.mn_i = i; end
      if (less(r.mx, v.w[i], v.sgn)) begin r.mx = v.w[i]; r.mx_i = i; end
      if (v.w[i] != v.w[0]) r.eq = 1'b0;
    end
    return r;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    int unsigned k;
    k = $urandom_range(0, 3);
    case (k)
      0:       w = 128'($urandom_range(0, 7));
      1:       w = MINN + 128'($urandom_range(0, 3));
      2:       w = MAXP - 128'($urandom_range(0, 3));
      default: w = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return w;
  endfunction

  task automatic send_word16(input word_t d, input bit last, input bit sgn);
    int t = 0;
    b16.in_valid = 1'b1; b16.in_data = d; b16.in_last = last; b16.signed_mode = sgn;
    while (!b16.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_ready", 128'(b16.in_ready), 128'(1));
    @(posedge clk); #1;
    b16.in_valid = 1'b0; b16.in_last = 1'b0; b16.signed_mode = ~sgn;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    for (int i = 0; i < v.n; i++)
      send_word16(v.w[i], (i == v.n - 1), (i == 0) ? v.sgn : ~v.sgn);
    if (v.n == 1) begin
      chk({tag, "_lat1"}, 128'(b16.out_valid), 128'(1));
    end else begin
      chk({tag, "_lat_a"}, 128'(b16.out_valid), 128'(0));
      @(posedge clk); #1;
      chk({tag, "_lat_b"}, 128'(b16.out_valid), 128'(0));
      @(posedge clk); #1;
      chk({tag, "_lat_c"}, 128'(b16.out_valid), 128'(1));
    end
    chk({tag, "_min"},    b16.out_min, v.mn);
    chk({tag, "_max"},    b16.out_max, v.mx);
    chk({tag, "_minidx"}, 128'(b16.out_min_idx), 128'(v.mn_i));
    chk({tag, "_maxidx"}, 128'(b16.out_max_idx), 128'(v.mx_i));
    chk({tag, "_count"},  128'(b16.out_count), 128'(v.n));
    chk({tag, "_alleq"},  128'(b16.out_all_eq), 128'(v.eq));
    chk({tag, "_ovf"},    128'(b16.out_ovf), 128'(0));
    chk({tag, "_inrdy_done"}, 128'(b16.in_ready), 128'(0));
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 128'(b16.out_valid), 128'(1));
      chk({tag, "_stall_min"},   b16.out_min, v.mn);
      chk({tag, "_stall_max"},   b16.out_max, v.mx);
      chk({tag, "_stall_inrdy"}, 128'(b16.in_ready), 128'(0));
    end
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 128'(b16.out_valid), 128'(0));
    chk({tag, "_idle_rdy"},   128'(b16.in_ready), 128'(1));
  endtask

  initial begin
    vec_t  tbl [7];
    vec_t  v;
    word_t w2 [5];
    int    t;

    tbl[0] = mk(5, 1'b0, 0, 128'd5, 128'd3, 128'd9, 128'd3, 128'd9,
                128'd3, 128'd9, 1, 2, 1'b0);
    tbl[1] = mk(3, 1'b1, 0, MAXP, MINN, 128'd1, '0, '0, MINN, MAXP, 1, 0, 1'b0);
    tbl[2] = mk(3, 1'b0, 0, MAXP, MINN, 128'd1, '0, '0, 128'd1, MINN, 2, 1, 1'b0);
    tbl[3] = mk(1, 1'b0, 0, 128'hDEAD, '0, '0, '0, '0, 128'hDEAD, 128'hDEAD, 0, 0, 1'b1);
    tbl[4] = mk(3, 1'b0, 5, 128'hA, 128'hA, 128'hA, '0, '0, 128'hA, 128'hA, 0, 0, 1'b1);
    tbl[5] = mk(3, 1'b1, 0, ONES, 128'd0, 128'd2, '0, '0, ONES, 128'd2, 0, 2, 1'b0);
    tbl[6] = mk(3, 1'b0, 1, ONES, 128'd0, 128'd2, '0, '0, 128'd0, ONES, 1, 0, 1'b0);

    reset = 1'b1;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_last = 1'b0;
    b16.signed_mode = 1'b0; b16.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0;
    b2.signed_mode = 1'b0; b2.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(b16.out_valid), 128'(0));
    chk("rst_ready", 128'(b16.in_ready), 128'(0));
    chk("rst_count", 128'(b16.out_count), 128'(0));
    chk("rst_min",   b16.out_min, '0);
    chk("rst_alleq", 128'(b16.out_all_eq), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 128'(b16.in_ready), 128'(1));

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a run, then a fresh run must be unaffected.
    send_word16(128'd1, 1'b0, 1'b0);
    send_word16(128'd2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 128'(b16.out_valid), 128'(0));
    chk("midrst_ready", 128'(b16.in_ready), 128'(0));
    @(posedge clk); #1;
    chk("midrst_valid2", 128'(b16.out_valid), 128'(0));
    reset = 1'b0;
    run_vec(mk(2, 1'b0, 0, 128'd4, 128'd2, '0, '0, '0, 128'd2, 128'd4, 1, 0, 1'b0), "after_rst");

    // Saturating 2-bit counter with five words.
    w2[0] = 128'd5; w2[1] = 128'd1; w2[2] = 128'd7; w2[3] = 128'd1; w2[4] = 128'd2;
    for (int i = 0; i < 5; i++) begin
      b2.in_valid = 1'b1; b2.in_data = w2[i]; b2.in_last = (i == 4); b2.signed_mode = 1'b0;
      t = 0;
      while (!b2.in_ready && t < 50) begin @(posedge clk); #1; t++; end
      chk("c2_accept_ready", 128'(b2.in_ready), 128'(1));
      @(posedge clk); #1;
      b2.in_valid = 1'b0; b2.in_last = 1'b0;
    end
    t = 0;
    while (!b2.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("c2_valid",  128'(b2.out_valid), 128'(1));
    chk("c2_count",  128'(b2.out_count), 128'(3));
    chk("c2_ovf",    128'(b2.out_ovf), 128'(1));
    chk("c2_min",    b2.out_min, 128'd1);
    chk("c2_max",    b2.out_max, 128'd7);
    chk("c2_minidx", 128'(b2.out_min_idx), 128'(1));
    chk("c2_maxidx", 128'(b2.out_max_idx), 128'(2));
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    chk("c2_valid_drop", 128'(b2.out_valid), 128'(0));

    // Random runs against the reference model.
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < 8; i++) v.w[i] = rand_word();
      if ($urandom_range(0, 3) == 0)
        for (int i = 1; i < 8; i++) v.w[i] = v.w[0];
      v.n = $urandom_range(1, 8);
      v.sgn = 1'($urandom_range(0, 1));
      v.stall = $urandom_range(0, 2);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
